// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the queue entry layout, the NOP filler and the instruction size.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; flush wins over push/pop.
// Ports: clk_i, rst_ni, push_i/data_i, pop_i/data_o, flush_i, full_o, empty_o, count_o.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  import fetch_pkg::*;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = nxt(wr_q);
      if (do_pop)  rd_d = nxt(rd_q);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: PC gen, credited imem requests, prefetch queue to decode.
// Ports: clk/rst, ex_if_* redirect, imem_req_*/imem_rsp_*, if_id_*; macro FETCH_BYPASS_EN.
module fetch_queue_stage #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_if_take_branch,
  input  logic [XLEN-1:0] ex_if_branch_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_id_valid,
  input  logic            if_id_ready,
  output logic [31:0]     if_id_instr_data,
  output logic [XLEN-1:0] if_id_pc
);
  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int EW = XLEN + 32;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [OW-1:0]   out_q, out_d;
  logic [OW-1:0]   drop_q, drop_d;

  logic            br, fire, accept, byp;
  logic [CW:0]     used;
  logic            q_push, q_pop, q_full, q_empty;
  logic [CW-1:0]   q_count;
  logic [EW-1:0]   q_head;
  logic [XLEN-1:0] pcf_head;
  logic            pcf_full, pcf_empty;
  logic [OW-1:0]   pcf_count;

  assign br = ex_if_take_branch;

  // Every in-flight request owns a queue slot before it is issued.
  assign used = (CW+1)'(q_count) + (CW+1)'(out_q);

  assign imem_req_valid = rst && !br
                       && (used < (CW+1)'(DEPTH))
                       && (out_q < OW'(MAX_OUTSTANDING));
  assign imem_req_addr  = pc_q;
  assign fire = imem_req_valid && imem_req_ready;

  assign accept = rst && imem_rsp_valid
               && (drop_q == '0) && !br;

`ifdef FETCH_BYPASS_EN
  assign byp = accept && q_empty;
`else
  assign byp = 1'b0;
`endif

  assign q_pop  = !br && !q_empty && if_id_ready;
  assign q_push = accept && !(byp && if_id_ready);

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (fire),
    .data_i  (pc_q),
    .pop_i   (accept),
    .flush_i (br),
    .data_o  (pcf_head),
    .full_o  (pcf_full),
    .empty_o (pcf_empty),
    .count_o (pcf_count)
  );

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (q_push),
    .data_i  ({pcf_head, imem_rsp_data}),
    .pop_i   (q_pop),
    .flush_i (br),
    .data_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  always_comb begin
    if_id_valid      = 1'b0;
    if_id_instr_data = NOP_INSTR;
    if_id_pc         = '0;
    if (!q_empty) begin
      if_id_valid      = !br;
      if_id_instr_data = q_head[31:0];
      if_id_pc         = q_head[EW-1:32];
    end else if (byp) begin
      if_id_valid      = 1'b1;
      if_id_instr_data = imem_rsp_data;
      if_id_pc         = pcf_head;
    end
  end

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q;
    drop_d = drop_q;
    if (br) begin
      pc_d = ex_if_branch_target
           & ~XLEN'(INSTR_BYTES - 1);
    end else if (fire) begin
      pc_d = pc_q + XLEN'(INSTR_BYTES);
    end
    unique case ({fire, imem_rsp_valid})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: ;
    endcase
    // A redirect re-derives the drop count from what is still in flight.
    if (br) begin
      drop_d = out_q - OW'(imem_rsp_valid);
    end else if (imem_rsp_valid && drop_q != '0) begin
      drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  a_q_ovf: assert property (@(posedge clk) disable iff (!rst)
    !(q_push && q_full && !q_pop));
  a_pcf_ovf: assert property (@(posedge clk) disable iff (!rst)
    fire |-> !pcf_full);
  a_pcf_tag: assert property (@(posedge clk) disable iff (!rst)
    accept |-> !pcf_empty);
  a_credit: assert property (@(posedge clk) disable iff (!rst)
    (pcf_count + drop_q) == out_q);
  a_rsp: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (out_q != '0));

endmodule
